// File: rtl/scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scoreboard_pkg
// Purpose  : Shared state encoding and sizing helper for the scoreboard
//            controller and its per-channel score keepers.
// Revision : 1.0 - initial release
// ============================================================================
package scoreboard_pkg;

  // Controller states: CLR waits for erase release, CNT accepts inc/dec.
  typedef enum logic [0:0] {
    ST_CLR = 1'b0,
    ST_CNT = 1'b1
  } state_t;

  // Width of the erase hold counter; never narrower than one bit.
  function automatic int erase_cnt_width(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_channel.sv
`default_nettype none
// ============================================================================
// Module   : score_channel
// Purpose  : One saturating score register with registered inc/dec accept
//            pulses and combinational saturation flags.
// Revision : 1.0 - initial release
// ============================================================================
module score_channel #(
  parameter int SCORE_W   = 8,
  parameter int STEP      = 1,
  parameter int MAX_SCORE = 99
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic               inc_o,
  output logic               dec_o,
  output logic [SCORE_W-1:0] score,
  output logic               sat_hi,
  output logic               sat_lo
);

  localparam logic [SCORE_W:0]   STEP_X = (SCORE_W + 1)'(STEP);
  localparam logic [SCORE_W:0]   MAX_X  = (SCORE_W + 1)'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] STEP_S = SCORE_W'(STEP);
  localparam logic [SCORE_W-1:0] MAX_S  = SCORE_W'(MAX_SCORE);

  // One extra bit so the increment can never wrap before clamping.
  logic [SCORE_W:0] sum_ext;
  assign sum_ext = {1'b0, score} + STEP_X;

  // Score register and accept pulses; erase/clear wins over any request.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      inc_o <= 1'b0;
      dec_o <= 1'b0;
      score <= '0;
    end else if (en && inc_i && !dec_i) begin
      inc_o <= 1'b1;
      dec_o <= 1'b0;
      score <= (sum_ext > MAX_X) ? MAX_S : sum_ext[SCORE_W-1:0];
    end else if (en && dec_i && !inc_i) begin
      inc_o <= 1'b0;
      dec_o <= 1'b1;
      score <= (score >= STEP_S) ? (score - STEP_S) : '0;
    end else begin
      inc_o <= 1'b0;
      dec_o <= 1'b0;
    end
  end

  assign sat_hi = (score == MAX_S);
  assign sat_lo = (score == '0);

endmodule
`default_nettype wire

// File: rtl/scoreboard_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : scoreboard_ctrl_multi
// Purpose  : Multi-channel score keeper with a held-erase controller. Erase
//            fires once after ERASE_HOLD consecutive high cycles and then
//            waits for erase_i to drop before counting resumes.
// Revision : 1.0 - initial release
// ============================================================================
module scoreboard_ctrl_multi
  import scoreboard_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int SCORE_W    = 8,
  parameter int STEP       = 1,
  parameter int MAX_SCORE  = 99,
  parameter int ERASE_HOLD = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         inc_i,
  input  logic [NUM_CH-1:0]         dec_i,
  input  logic                      erase_i,
  output logic [NUM_CH-1:0]         inc_o,
  output logic [NUM_CH-1:0]         dec_o,
  output logic                      erase_o,
  output logic [NUM_CH*SCORE_W-1:0] score_o,
  output logic [NUM_CH-1:0]         sat_hi_o,
  output logic [NUM_CH-1:0]         sat_lo_o
);

  localparam int            CW       = erase_cnt_width(ERASE_HOLD);
  localparam logic [CW-1:0] CNT_LAST = CW'(ERASE_HOLD - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] erase_cnt;
  logic [CW-1:0] erase_cnt_nxt;
  logic          erase_fire;
  logic          count_en;

  assign count_en = (state == ST_CNT);

  // Next-state, hold counter and erase-fire decode.
  always_comb begin
    state_nxt     = state;
    erase_cnt_nxt = '0;
    erase_fire    = 1'b0;
    case (state)
      ST_CLR: begin
        // Stay parked until erase is released so one hold fires only once.
        if (!erase_i) state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (erase_i) begin
          if (erase_cnt == CNT_LAST) begin
            erase_fire = 1'b1;
            state_nxt  = ST_CLR;
          end else begin
            erase_cnt_nxt = erase_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_CLR;
    endcase
  end

  // State register, hold counter and registered erase pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_CLR;
      erase_cnt <= '0;
      erase_o   <= 1'b0;
    end else begin
      state     <= state_nxt;
      erase_cnt <= erase_cnt_nxt;
      erase_o   <= erase_fire;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    score_channel #(
      .SCORE_W  (SCORE_W),
      .STEP     (STEP),
      .MAX_SCORE(MAX_SCORE)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .en    (count_en),
      .clr   (erase_fire),
      .inc_i (inc_i[c]),
      .dec_i (dec_i[c]),
      .inc_o (inc_o[c]),
      .dec_o (dec_o[c]),
      .score (score_o[c*SCORE_W +: SCORE_W]),
      .sat_hi(sat_hi_o[c]),
      .sat_lo(sat_lo_o[c])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_scoreboard_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_scoreboard_ctrl_multi
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            randomized traffic against a behavioural score/erase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scoreboard_ctrl_multi;

  localparam int NUM_CH     = 2;
  localparam int SCORE_W    = 8;
  localparam int STEP       = 1;
  localparam int MAX_SCORE  = 99;
  localparam int ERASE_HOLD = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (default parameters)
  logic                      rst;
  logic [NUM_CH-1:0]         inc_i, dec_i;
  logic                      erase_i;
  logic [NUM_CH-1:0]         inc_o, dec_o, sat_hi_o, sat_lo_o;
  logic                      erase_o;
  logic [NUM_CH*SCORE_W-1:0] score_o;

  // Second DUT with a short erase hold
  logic                      rst3;
  logic [NUM_CH-1:0]         inc3, dec3;
  logic                      erase3;
  logic [NUM_CH-1:0]         inc3_o, dec3_o, sat_hi3, sat_lo3;
  logic                      erase3_o;
  logic [NUM_CH*SCORE_W-1:0] score3;

  scoreboard_ctrl_multi #(
    .NUM_CH(NUM_CH), .SCORE_W(SCORE_W), .STEP(STEP),
    .MAX_SCORE(MAX_SCORE), .ERASE_HOLD(ERASE_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .inc_i(inc_i), .dec_i(dec_i), .erase_i(erase_i),
    .inc_o(inc_o), .dec_o(dec_o), .erase_o(erase_o), .score_o(score_o),
    .sat_hi_o(sat_hi_o), .sat_lo_o(sat_lo_o)
  );

  scoreboard_ctrl_multi #(
    .NUM_CH(NUM_CH), .SCORE_W(SCORE_W), .STEP(STEP),
    .MAX_SCORE(MAX_SCORE), .ERASE_HOLD(3)
  ) dut3 (
    .clk(clk), .rst(rst3), .inc_i(inc3), .dec_i(dec3), .erase_i(erase3),
    .inc_o(inc3_o), .dec_o(dec3_o), .erase_o(erase3_o), .score_o(score3),
    .sat_hi_o(sat_hi3), .sat_lo_o(sat_lo3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sc(input int c);
    return int'(score_o[c*SCORE_W +: SCORE_W]);
  endfunction

  // ---------------- behavioural reference model ----------------
  // Scores as plain integers; "waiting" means an erase fired (or reset) and
  // the erase request has not yet been seen low; "run" counts consecutive
  // erase-high cycles while counting is live.
  int   m_score[NUM_CH];
  int   m_run;
  bit   m_waiting;
  logic [NUM_CH-1:0] m_inc, m_dec;
  logic m_erase;

  task automatic model_step();
    m_inc = '0; m_dec = '0; m_erase = 1'b0;
    if (rst) begin
      foreach (m_score[c]) m_score[c] = 0;
      m_run = 0; m_waiting = 1'b1;
    end else if (m_waiting) begin
      m_run = 0;
      if (!erase_i) m_waiting = 1'b0;
    end else begin
      m_run = erase_i ? m_run + 1 : 0;
      if (m_run == ERASE_HOLD) begin
        m_erase = 1'b1;
        foreach (m_score[c]) m_score[c] = 0;
        m_run = 0; m_waiting = 1'b1;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (inc_i[c] && !dec_i[c]) begin
            m_inc[c] = 1'b1;
            m_score[c] = (m_score[c] + STEP > MAX_SCORE) ? MAX_SCORE : m_score[c] + STEP;
          end else if (dec_i[c] && !inc_i[c]) begin
            m_dec[c] = 1'b1;
            m_score[c] = (m_score[c] >= STEP) ? m_score[c] - STEP : 0;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    chk("model erase_o", 32'(erase_o), 32'(m_erase));
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("model inc_o[%0d]", c), 32'(inc_o[c]), 32'(m_inc[c]));
      chk($sformatf("model dec_o[%0d]", c), 32'(dec_o[c]), 32'(m_dec[c]));
      chk($sformatf("model score[%0d]", c), 32'(sc(c)), 32'(m_score[c]));
      chk($sformatf("model sat_hi[%0d]", c), 32'(sat_hi_o[c]), 32'(m_score[c] == MAX_SCORE));
      chk($sformatf("model sat_lo[%0d]", c), 32'(sat_lo_o[c]), 32'(m_score[c] == 0));
    end
  endtask

  // One clock: inputs already driven; sample at the edge, check 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic drive(input logic r, input logic [1:0] inc, input logic [1:0] dec, input logic er);
    rst = r; inc_i = inc; dec_i = dec; erase_i = er;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [1:0] inc;
    logic [1:0] dec;
    logic       erase;
    logic [1:0] e_inc;
    logic [1:0] e_dec;
    logic       e_erase;
    int         e_s0;
    int         e_s1;
  } vec_t;

  vec_t tbl[15];
  int   exp3[5];

  initial begin
    tbl[0]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 0, 0};
    tbl[1]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 0, 0};
    tbl[2]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 0, 0};
    tbl[3]  = '{1'b0, 2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1, 0};
    tbl[4]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1, 0};
    tbl[5]  = '{1'b0, 2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 2, 0};
    tbl[6]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2, 0};
    tbl[7]  = '{1'b0, 2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 3, 0};
    tbl[8]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 3, 0};
    tbl[9]  = '{1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 3, 0};
    tbl[10] = '{1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 3, 0};
    tbl[11] = '{1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 3, 0};
    tbl[12] = '{1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 3, 0};
    tbl[13] = '{1'b0, 2'b00, 2'b10, 1'b0, 2'b00, 2'b10, 1'b0, 3, 0};
    tbl[14] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 3, 0};
    exp3 = '{98, 99, 99, 99, 99};

    rst3 = 1'b1; inc3 = '0; dec3 = '0; erase3 = 1'b0;
    foreach (m_score[c]) m_score[c] = 0;
    m_run = 0; m_waiting = 1'b1;
    drive(1'b1, 2'b00, 2'b00, 1'b0);

    // Reset, single increments on ch0, contention and floor on ch1
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].inc, tbl[i].dec, tbl[i].erase);
      tick();
      chk($sformatf("tbl[%0d] inc_o", i), 32'(inc_o), 32'(tbl[i].e_inc));
      chk($sformatf("tbl[%0d] dec_o", i), 32'(dec_o), 32'(tbl[i].e_dec));
      chk($sformatf("tbl[%0d] erase_o", i), 32'(erase_o), 32'(tbl[i].e_erase));
      chk($sformatf("tbl[%0d] score0", i), 32'(sc(0)), 32'(tbl[i].e_s0));
      chk($sformatf("tbl[%0d] score1", i), 32'(sc(1)), 32'(tbl[i].e_s1));
      chk($sformatf("tbl[%0d] sat_lo", i), 32'(sat_lo_o),
          32'({tbl[i].e_s1 == 0, tbl[i].e_s0 == 0}));
      chk($sformatf("tbl[%0d] sat_hi", i), 32'(sat_hi_o), 32'(2'b00));
    end

    // Climb ch0 from 3 to 97, then hold inc across the ceiling
    drive(1'b0, 2'b01, 2'b00, 1'b0);
    for (int i = 0; i < 94; i++) tick();
    chk("sat pre score0", 32'(sc(0)), 32'd97);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("sat score0 #%0d", i), 32'(sc(0)), 32'(exp3[i]));
      chk($sformatf("sat inc_o0 #%0d", i), 32'(inc_o[0]), 32'd1);
      chk($sformatf("sat sat_hi0 #%0d", i), 32'(sat_hi_o[0]), 32'(i >= 1));
    end

    // Clear via a full hold, release, then build ch0=5 ch1=7
    drive(1'b0, 2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("clear erase_o", 32'(erase_o), 32'd1);
    drive(1'b0, 2'b00, 2'b00, 1'b0);
    tick();
    drive(1'b0, 2'b11, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    drive(1'b0, 2'b10, 2'b00, 1'b0);
    for (int i = 0; i < 2; i++) tick();
    chk("build score0", 32'(sc(0)), 32'd5);
    chk("build score1", 32'(sc(1)), 32'd7);

    // Hold one cycle short of the threshold: no erase
    drive(1'b0, 2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("short hold erase_o", 32'(erase_o), 32'd0);
    end
    drive(1'b0, 2'b00, 2'b00, 1'b0);
    tick();
    chk("short hold score0", 32'(sc(0)), 32'd5);
    chk("short hold score1", 32'(sc(1)), 32'd7);

    // Full hold with a same-cycle increment on the firing cycle
    drive(1'b0, 2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    drive(1'b0, 2'b01, 2'b00, 1'b1);
    tick();
    chk("fire erase_o", 32'(erase_o), 32'd1);
    chk("fire inc_o0", 32'(inc_o[0]), 32'd0);
    chk("fire scores", 32'(score_o), 32'd0);

    // Keep holding: no re-fire, increments ignored
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("held erase_o", 32'(erase_o), 32'd0);
      chk("held inc_o0", 32'(inc_o[0]), 32'd0);
    end
    drive(1'b0, 2'b01, 2'b00, 1'b0);
    tick();
    chk("release inc_o0", 32'(inc_o[0]), 32'd0);
    tick();
    chk("resume inc_o0", 32'(inc_o[0]), 32'd1);
    chk("resume score0", 32'(sc(0)), 32'd1);

    // Short-hold instance: reset mid-hold must cancel the pending erase
    drive(1'b0, 2'b00, 2'b00, 1'b0);
    rst3 = 1'b1; erase3 = 1'b0; tick(); tick();
    rst3 = 1'b0; tick();
    erase3 = 1'b1; tick();
    chk("h3 first high erase_o", 32'(erase3_o), 32'd0);
    rst3 = 1'b1; tick();
    chk("h3 rst mid-hold erase_o", 32'(erase3_o), 32'd0);
    rst3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("h3 parked erase_o", 32'(erase3_o), 32'd0);
    end
    erase3 = 1'b0; tick();
    erase3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("h3 fresh hold #%0d", i), 32'(erase3_o), 32'(i == 2));
    end
    tick();
    chk("h3 single pulse", 32'(erase3_o), 32'd0);
    erase3 = 1'b0;

    // Randomized traffic with bursty erase holds and occasional reset
    begin
      bit hold_mode = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 19) == 0) hold_mode = ~hold_mode;
        drive($urandom_range(0, 99) == 0,
              2'($urandom), 2'($urandom),
              hold_mode ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 9) == 0));
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
